// File: rtl/lsu_mem_arbiter.sv
// Two-master arbiter sharing one memory port between the LSU and an external master.
// One access in flight at a time; alternating priority on contention; timeout abort sets a sticky err.
module lsu_mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_cs,
    input  logic        core_wr,
    input  logic [3:0]  core_mask,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic [31:0] core_rdata,
    input  logic        ext_req,
    input  logic        ext_wr,
    input  logic [3:0]  ext_mask,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_done,
    output logic [31:0] ext_rdata,
    output logic        mem_cs,
    output logic        mem_wr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CORE_BUSY = 3'd1,
        CORE_DONE = 3'd2,
        EXT_BUSY  = 3'd3,
        EXT_DONE  = 3'd4
    } state_t;

    localparam logic       GRANT_CORE = 1'b0;
    localparam logic       GRANT_EXT  = 1'b1;
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    // Handshakes: the core holds core_cs low with stable fields until it sees
    // core_stall low (one cycle, data in core_rdata); the external master holds
    // ext_req high with stable fields until ext_done pulses (data in ext_rdata).
    // Requests still asserted during a DONE cycle are treated as new requests.

    state_t      state, state_next;
    logic        last_grant;
    logic [7:0]  wait_cnt;
    logic        issue, issue_ext, finish, abort, busy;
    logic [31:0] resp_data;

    assign busy       = (state == CORE_BUSY) || (state == EXT_BUSY);
    assign core_stall = !core_cs && (state != CORE_DONE);
    assign ext_done   = (state == EXT_DONE);
    assign dbg_state  = state;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_ext  = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        resp_data  = '0;
        case (state)
            IDLE: begin
                // Core wins unless the external master is also waiting and the core went last.
                if (!core_cs && (!ext_req || last_grant == GRANT_EXT)) begin
                    issue      = 1'b1;
                    state_next = CORE_BUSY;
                end else if (ext_req) begin
                    issue      = 1'b1;
                    issue_ext  = 1'b1;
                    state_next = EXT_BUSY;
                end
            end
            CORE_BUSY, EXT_BUSY: begin
                if (mem_ack) begin
                    finish    = 1'b1;
                    resp_data = mem_wr ? mem_rdata : 32'h0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    abort = 1'b1;
                end
                if (finish || abort) begin
                    state_next = (state == CORE_BUSY) ? CORE_DONE : EXT_DONE;
                end
            end
            CORE_DONE, EXT_DONE: state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            mem_cs     <= 1'b1;
            mem_wr     <= 1'b1;
            mem_mask   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            ext_rdata  <= '0;
            err        <= 1'b0;
            wait_cnt   <= '0;
            last_grant <= GRANT_EXT;
        end else begin
            state <= state_next;
            if (issue) begin
                mem_cs     <= 1'b0;
                mem_wr     <= issue_ext ? ext_wr    : core_wr;
                mem_mask   <= issue_ext ? ext_mask  : core_mask;
                mem_addr   <= issue_ext ? ext_addr  : core_addr;
                mem_wdata  <= issue_ext ? ext_wdata : core_wdata;
                wait_cnt   <= '0;
                last_grant <= issue_ext ? GRANT_EXT : GRANT_CORE;
            end else if (finish || abort) begin
                mem_cs <= 1'b1;
                if (state == CORE_BUSY) begin
                    core_rdata <= resp_data;
                end else begin
                    ext_rdata <= resp_data;
                end
                if (abort) begin
                    err <= 1'b1;
                end
            end else if (busy) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: directed scenarios plus randomized concurrent traffic,
// with per-master expected-response queues and a memory responder model.
module tb_lsu_mem_arbiter;

    localparam int TIMEOUT = 4;
    localparam int BOUND   = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_cs = 1'b1, core_wr = 1'b1;
    logic [3:0]  core_mask = '0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        ext_req = 1'b0, ext_wr = 1'b1;
    logic [3:0]  ext_mask = '0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic        ext_done;
    logic [31:0] ext_rdata;
    logic        mem_cs, mem_wr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;
    logic [2:0]  dbg_state;

    int          compared = 0;
    int          mismatched = 0;
    logic [32:0] core_exp_q[$];
    logic [32:0] ext_exp_q[$];
    bit          grant_log[$];
    int          force_delay = -1;
    bit          rdata_ovr_en = 1'b0;
    logic [31:0] rdata_ovr = '0;
    bit          spurious_en = 1'b0;
    bit          model_err = 1'b0;
    int          busy_cnt = 0;
    logic        prev_cs = 1'b1;
    bit          owner_ext = 1'b0;
    logic [68:0] want = '0;
    logic [32:0] e_core, e_ext;

    lsu_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .core_cs(core_cs), .core_wr(core_wr), .core_mask(core_mask),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rdata(core_rdata),
        .ext_req(ext_req), .ext_wr(ext_wr), .ext_mask(ext_mask),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_done(ext_done), .ext_rdata(ext_rdata),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic int delay_for(input logic [31:0] addr);
        return (force_delay >= 0) ? force_delay : int'(addr[2:0]);
    endfunction

    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        return rdata_ovr_en ? rdata_ovr : ({addr[15:0], ~addr[31:16]} ^ 32'h1357_9bdf);
    endfunction

    // Expected response: {timed_out, rdata}. Ack on BUSY cycle d succeeds only if d < TIMEOUT.
    function automatic logic [32:0] expect_resp(input logic wr, input logic [31:0] addr);
        if (delay_for(addr) >= TIMEOUT) return {1'b1, 32'h0};
        return {1'b0, wr ? mem_fn(addr) : 32'h0};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input logic exp_stall);
        check("rst_mem_cs", mem_cs, 1'b1);
        check("rst_mem_wr", mem_wr, 1'b1);
        check("rst_mem_mask", mem_mask, 4'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_core_rdata", core_rdata, 32'h0);
        check("rst_ext_rdata", ext_rdata, 32'h0);
        check("rst_ext_done", ext_done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_core_stall", core_stall, exp_stall);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        core_cs = 1'b1;
        ext_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_err = 1'b0;
    endtask

    // driver tasks: called at posedge+1, return at posedge+1 of the cycle after completion
    task automatic core_issue(input logic wr, input logic [3:0] mask, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit keep,
                              output int stall_cyc, output int cs_cyc);
        int n;
        n = 0;
        stall_cyc = 0;
        cs_cyc = 0;
        core_wr = wr; core_mask = mask; core_addr = addr; core_wdata = wdata;
        core_cs = 1'b0;
        core_exp_q.push_back(expect_resp(wr, addr));
        do begin
            @(negedge clk);
            n++;
            stall_cyc += int'(core_stall);
            cs_cyc += int'(!mem_cs);
        end while (core_stall && n < BOUND);
        if (core_stall) begin
            compared++;
            mismatched++;
            $display("FAIL core_wait_bound: still stalled after %0d cycles, state %0d", n, dbg_state);
        end
        @(posedge clk);
        #1;
        if (!keep) core_cs = 1'b1;
    endtask

    task automatic ext_issue(input logic wr, input logic [3:0] mask, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit keep);
        int n;
        n = 0;
        ext_wr = wr; ext_mask = mask; ext_addr = addr; ext_wdata = wdata;
        ext_req = 1'b1;
        ext_exp_q.push_back(expect_resp(wr, addr));
        do begin
            @(negedge clk);
            n++;
        end while (!ext_done && n < BOUND);
        if (!ext_done) begin
            compared++;
            mismatched++;
            $display("FAIL ext_wait_bound: no ext_done after %0d cycles, state %0d", n, dbg_state);
        end
        @(posedge clk);
        #1;
        if (!keep) ext_req = 1'b0;
    endtask

    // memory responder: ack on BUSY cycle delay_for(addr); optional stray acks while idle
    initial begin
        forever begin
            @(negedge clk);
            if (mem_cs === 1'b0) begin
                mem_ack = (busy_cnt == delay_for(mem_addr));
                mem_rdata = mem_fn(mem_addr);
                busy_cnt++;
            end else begin
                busy_cnt = 0;
                mem_ack = spurious_en && ($urandom_range(0, 2) == 0);
                mem_rdata = $urandom();
            end
        end
    end

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!core_cs && !core_stall) begin
                    if (core_exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL core_done_unexpected: rdata %h, nothing expected", core_rdata);
                    end else begin
                        e_core = core_exp_q.pop_front();
                        if (e_core[32]) model_err = 1'b1;
                        check("core_rdata", core_rdata, e_core[31:0]);
                        check("err_at_core_done", err, model_err);
                    end
                end
                if (ext_done) begin
                    if (ext_exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL ext_done_unexpected: rdata %h, nothing expected", ext_rdata);
                    end else begin
                        e_ext = ext_exp_q.pop_front();
                        if (e_ext[32]) model_err = 1'b1;
                        check("ext_rdata", ext_rdata, e_ext[31:0]);
                        check("err_at_ext_done", err, model_err);
                    end
                end
                if (!mem_cs) begin
                    if (prev_cs) begin
                        owner_ext = (!core_cs && ext_req) ? mem_addr[31] : ext_req;
                        grant_log.push_back(owner_ext);
                        want = owner_ext ? {ext_wr, ext_mask, ext_addr, ext_wdata}
                                         : {core_wr, core_mask, core_addr, core_wdata};
                        check("mem_issue_fields", {mem_wr, mem_mask, mem_addr, mem_wdata}, want);
                    end else begin
                        check("mem_fields_stable", {mem_wr, mem_mask, mem_addr, mem_wdata}, want);
                    end
                end
            end
            prev_cs = mem_cs;
        end
    end

    initial begin
        int sc, cc, sc2, cc2, n;
        logic [3:0] order;

        do_reset();

        // core load, ack on second BUSY cycle
        force_delay = 1;
        rdata_ovr_en = 1'b1;
        rdata_ovr = 32'hDEADBEEF;
        core_issue(1'b1, 4'hf, 32'h100, 32'h0, 1'b0, sc, cc);
        check("load_stall_cycles", sc, 3);
        check("load_cs_low_cycles", cc, 2);
        rdata_ovr_en = 1'b0;

        // external store, immediate ack
        force_delay = 0;
        ext_issue(1'b0, 4'b0011, 32'h40, 32'h1234, 1'b0);
        @(negedge clk);
        check("ext_done_single_pulse", ext_done, 1'b0);
        @(posedge clk);
        #1;

        // simultaneous requests held back-to-back: grants alternate core, ext, core, ext
        do_reset();
        grant_log.delete();
        force_delay = 1;
        fork
            begin
                core_issue(1'b1, 4'hf, 32'h200, 32'h0, 1'b1, sc, cc);
                core_issue(1'b0, 4'h5, 32'h204, 32'hcafe, 1'b0, sc2, cc2);
            end
            begin
                ext_issue(1'b1, 4'hf, 32'h8000_0300, 32'h0, 1'b1);
                ext_issue(1'b0, 4'ha, 32'h8000_0304, 32'hbeef, 1'b0);
            end
        join
        order = '0;
        for (int i = 0; i < 4 && i < grant_log.size(); i++) order[i] = grant_log[i];
        check("grant_count", grant_log.size(), 4);
        check("grant_order", order, 4'b1010);

        // reset during EXT_BUSY abandons the access, then a core request completes
        do_reset();
        force_delay = 255;
        ext_wr = 1'b1; ext_mask = 4'hf; ext_addr = 32'h8000_0080; ext_wdata = 32'h0;
        ext_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_cs && n < BOUND);
        check("ext_entered_busy", mem_cs, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ext_req = 1'b0;
        core_wr = 1'b1; core_mask = 4'hf; core_addr = 32'h300; core_wdata = 32'h0;
        core_cs = 1'b0;
        @(negedge clk);
        check("stall_during_reset", core_stall, 1'b1);
        check("no_ext_done_in_reset", ext_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_err = 1'b0;
        force_delay = 1;
        fork
            core_issue(1'b1, 4'hf, 32'h300, 32'h0, 1'b0, sc, cc);
            begin
                @(negedge clk);
                check_reset_outputs(1'b1);
            end
        join

        // timeout: no ack ever; stray acks afterwards must be ignored
        force_delay = 255;
        spurious_en = 1'b1;
        core_issue(1'b1, 4'hf, 32'h104, 32'h0, 1'b0, sc, cc);
        check("timeout_stall_cycles", sc, 5);
        check("timeout_busy_cycles", cc, 4);
        repeat (8) begin
            @(negedge clk);
            check("err_sticky", err, 1'b1);
            check("late_ack_no_issue", mem_cs, 1'b1);
            check("timeout_rdata_held", core_rdata, 32'h0);
        end
        @(posedge clk);
        #1;

        // randomized concurrent traffic
        do_reset();
        force_delay = -1;
        spurious_en = 1'b1;
        fork
            for (int i = 0; i < 30; i++) begin
                int rs, rc, g;
                bit keep;
                keep = 1'($urandom_range(0, 1));
                core_issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                           $urandom() & 32'h7fff_ffff, $urandom(), keep, rs, rc);
                if (!keep) begin
                    g = $urandom_range(0, 3);
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            for (int j = 0; j < 30; j++) begin
                int g;
                bit keep;
                keep = 1'($urandom_range(0, 1));
                ext_issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          $urandom() | 32'h8000_0000, $urandom(), keep);
                if (!keep) begin
                    g = $urandom_range(0, 3);
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
        join
        core_cs = 1'b1;
        ext_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("core_queue_drained", core_exp_q.size(), 0);
        check("ext_queue_drained", ext_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
